id_ex_alu_issue: RTL and testbench

//  ID/EX pipeline stage driving the EX-stage ALU: decodes the ID instruction into ALUConf/Sign,

---
 rtl/alu_issue_pkg.sv | 97 +++++++++
 rtl/alu_op_decoder.sv | 102 ++++++++++
 rtl/id_ex_alu_issue.sv | 88 ++++++++
 tb/tb_id_ex_alu_issue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared constants and payload types for the ID/EX ALU issue stage.
// Build option: ALU_ISSUE_ILLEGAL_TRAP_EN (consumed by id_ex_alu_issue).
package alu_issue_pkg;

   localparam int unsigned DW = 32;
   localparam int unsigned RW = 5;

   // ALU operation codes
   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_SUB = 5'd1;
   localparam logic [4:0] ALU_AND = 5'd2;
   localparam logic [4:0] ALU_OR  = 5'd3;
   localparam logic [4:0] ALU_XOR = 5'd4;
   localparam logic [4:0] ALU_NOR = 5'd5;
   localparam logic [4:0] ALU_SLL = 5'd6;
   localparam logic [4:0] ALU_SRL = 5'd7;
   localparam logic [4:0] ALU_SRA = 5'd8;
   localparam logic [4:0] ALU_SLT = 5'd9;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_SLLV = 6'h04;
   localparam logic [5:0] F_SRLV = 6'h06;
   localparam logic [5:0] F_SRAV = 6'h07;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   typedef enum logic [1:0] {IN1_RS, IN1_SHAMT, IN1_RS5, IN1_C16} in1_sel_e;
   typedef enum logic       {IN2_RT, IN2_IMM} in2_sel_e;

   typedef struct packed {
      logic [4:0]    conf;
      logic          sign;
      in1_sel_e      in1_sel;
      in2_sel_e      in2_sel;
      logic [RW-1:0] rs;
      logic [RW-1:0] rt;
      logic [RW-1:0] rd;
      logic [RW-1:0] shamt;
      logic [DW-1:0] imm;
      logic          reg_wr;
      logic          illegal;
   } dec_t;

   typedef struct packed {
      logic          valid;
      logic [4:0]    conf;
      logic          sign;
      logic [DW-1:0] in1;
      logic [DW-1:0] in2;
      logic [RW-1:0] rd;
      logic          reg_wr;
      logic          illegal;
   } ex_t;

   // Youngest producer wins; register 0 is never forwarded.
   function automatic logic [DW-1:0] fwd_mux(input logic [RW-1:0] src,
                                             input logic [DW-1:0] rf_data,
                                             input logic          exm_wr,
                                             input logic [RW-1:0] exm_rd,
                                             input logic [DW-1:0] exm_data,
                                             input logic          mwb_wr,
                                             input logic [RW-1:0] mwb_rd,
                                             input logic [DW-1:0] mwb_data);
      logic [DW-1:0] r;
      r = rf_data;
      if (src != RW'(0)) begin
         if (exm_wr && (exm_rd == src))      r = exm_data;
         else if (mwb_wr && (mwb_rd == src)) r = mwb_data;
      end
      return r;
   endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// Combinational MIPS decode: instruction word -> ALU conf/sign, operand selects,
// destination register, write enable and illegal flag.
import alu_issue_pkg::*;

module alu_op_decoder (
   input  logic [DW-1:0] instr,
   output dec_t          dec
);

   logic [5:0]  op;
   logic [5:0]  funct;
   logic [15:0] imm16;

   always_comb begin
      op    = instr[31:26];
      funct = instr[5:0];
      imm16 = instr[15:0];

      dec         = '0;
      dec.conf    = ALU_ADD;
      dec.in1_sel = IN1_RS;
      dec.in2_sel = IN2_RT;
      dec.rs      = instr[25:21];
      dec.rt      = instr[20:16];
      dec.rd      = instr[20:16];
      dec.shamt   = instr[10:6];
      dec.imm     = {{16{imm16[15]}}, imm16};

      case (op)
         OP_RTYPE: begin
            dec.rd     = instr[15:11];
            dec.reg_wr = (instr[15:11] != 5'd0);
            case (funct)
               F_ADD, F_ADDU: begin
                  dec.conf = ALU_ADD;
                  dec.sign = (funct == F_ADD);
               end
               F_SUB, F_SUBU: begin
                  dec.conf = ALU_SUB;
                  dec.sign = (funct == F_SUB);
               end
               F_SLT, F_SLTU: begin
                  dec.conf = ALU_SLT;
                  dec.sign = (funct == F_SLT);
               end
               F_AND:  dec.conf = ALU_AND;
               F_OR:   dec.conf = ALU_OR;
               F_XOR:  dec.conf = ALU_XOR;
               F_NOR:  dec.conf = ALU_NOR;
               F_SLL:  begin dec.conf = ALU_SLL; dec.in1_sel = IN1_SHAMT; end
               F_SRL:  begin dec.conf = ALU_SRL; dec.in1_sel = IN1_SHAMT; end
               F_SRA:  begin dec.conf = ALU_SRA; dec.in1_sel = IN1_SHAMT; end
               F_SLLV: begin dec.conf = ALU_SLL; dec.in1_sel = IN1_RS5;   end
               F_SRLV: begin dec.conf = ALU_SRL; dec.in1_sel = IN1_RS5;   end
               F_SRAV: begin dec.conf = ALU_SRA; dec.in1_sel = IN1_RS5;   end
               default: begin
                  dec.illegal = 1'b1;
                  dec.reg_wr  = 1'b0;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec.conf    = ALU_ADD;
            dec.sign    = (op == OP_ADDI);
            dec.in2_sel = IN2_IMM;
            dec.reg_wr  = 1'b1;
         end
         OP_SLTI, OP_SLTIU: begin
            dec.conf    = ALU_SLT;
            dec.sign    = (op == OP_SLTI);
            dec.in2_sel = IN2_IMM;
            dec.reg_wr  = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            dec.conf    = (op == OP_ANDI) ? ALU_AND : (op == OP_ORI) ? ALU_OR : ALU_XOR;
            dec.imm     = {16'h0000, imm16};
            dec.in2_sel = IN2_IMM;
            dec.reg_wr  = 1'b1;
         end
         // lui is issued as a 16-bit left shift of the zero-extended immediate
         OP_LUI: begin
            dec.conf    = ALU_SLL;
            dec.in1_sel = IN1_C16;
            dec.imm     = {16'h0000, imm16};
            dec.in2_sel = IN2_IMM;
            dec.reg_wr  = 1'b1;
         end
         OP_LW, OP_SW: begin
            dec.conf    = ALU_ADD;
            dec.in2_sel = IN2_IMM;
            dec.reg_wr  = (op == OP_LW);
         end
         OP_BEQ, OP_BNE: begin
            dec.conf = ALU_SUB;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/id_ex_alu_issue.sv
// ID/EX register feeding the EX ALU: decode, operand forwarding, stall/flush.
// Build option: ALU_ISSUE_ILLEGAL_TRAP_EN issues illegal instructions as flagged no-write ops.
import alu_issue_pkg::*;

module id_ex_alu_issue (
   input  logic          clk,
   input  logic          reset,
   input  logic          id_valid,
   input  logic [31:0]   id_instr,
   input  logic [31:0]   id_rs_data,
   input  logic [31:0]   id_rt_data,
   input  logic          exm_wr,
   input  logic [4:0]    exm_rd,
   input  logic [31:0]   exm_data,
   input  logic          mwb_wr,
   input  logic [4:0]    mwb_rd,
   input  logic [31:0]   mwb_data,
   input  logic          stall,
   input  logic          flush,
   output logic          ex_valid,
   output logic [4:0]    ex_alu_conf,
   output logic          ex_alu_sign,
   output logic [31:0]   ex_alu_in1,
   output logic [31:0]   ex_alu_in2,
   output logic [4:0]    ex_rd,
   output logic          ex_reg_wr,
   output logic          ex_illegal
);

   dec_t          dec;
   ex_t           load;
   ex_t           ex_d;
   ex_t           ex_q;
   logic [DW-1:0] rs_fwd;
   logic [DW-1:0] rt_fwd;

   alu_op_decoder u_dec (
      .instr (id_instr),
      .dec   (dec)
   );

   // Build the would-be EX payload, then apply flush/stall priority.
   always_comb begin
      rs_fwd = fwd_mux(dec.rs, id_rs_data, exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data);
      rt_fwd = fwd_mux(dec.rt, id_rt_data, exm_wr, exm_rd, exm_data, mwb_wr, mwb_rd, mwb_data);

      load = '0;
      if (id_valid && !dec.illegal) begin
         load.valid  = 1'b1;
         load.conf   = dec.conf;
         load.sign   = dec.sign;
         load.rd     = dec.rd;
         load.reg_wr = dec.reg_wr;
         case (dec.in1_sel)
            IN1_SHAMT: load.in1 = {27'b0, dec.shamt};
            IN1_RS5:   load.in1 = {27'b0, rs_fwd[4:0]};
            IN1_C16:   load.in1 = DW'(16);
            default:   load.in1 = rs_fwd;
         endcase
         load.in2 = (dec.in2_sel == IN2_IMM) ? dec.imm : rt_fwd;
      end
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      else if (id_valid) begin
         load.valid   = 1'b1;
         load.illegal = 1'b1;
      end
`endif

      ex_d = ex_q;
      if (flush)       ex_d = '0;
      else if (!stall) ex_d = load;
   end

   always_ff @(posedge clk) begin
      if (reset) ex_q <= '0;
      else       ex_q <= ex_d;
   end

   assign ex_valid    = ex_q.valid;
   assign ex_alu_conf = ex_q.conf;
   assign ex_alu_sign = ex_q.sign;
   assign ex_alu_in1  = ex_q.in1;
   assign ex_alu_in2  = ex_q.in2;
   assign ex_rd       = ex_q.rd;
   assign ex_reg_wr   = ex_q.reg_wr;
   assign ex_illegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: driver queues hand-computed EX contents per edge,
// monitor pops and compares on the following falling edge.
module tb_id_ex_alu_issue;

   logic        clk;
   logic        reset;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic        exm_wr;
   logic [4:0]  exm_rd;
   logic [31:0] exm_data;
   logic        mwb_wr;
   logic [4:0]  mwb_rd;
   logic [31:0] mwb_data;
   logic        stall;
   logic        flush;
   logic        ex_valid;
   logic [4:0]  ex_alu_conf;
   logic        ex_alu_sign;
   logic [31:0] ex_alu_in1;
   logic [31:0] ex_alu_in2;
   logic [4:0]  ex_rd;
   logic        ex_reg_wr;
   logic        ex_illegal;

   id_ex_alu_issue dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
      .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
      .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
      .stall(stall), .flush(flush),
      .ex_valid(ex_valid), .ex_alu_conf(ex_alu_conf), .ex_alu_sign(ex_alu_sign),
      .ex_alu_in1(ex_alu_in1), .ex_alu_in2(ex_alu_in2), .ex_rd(ex_rd),
      .ex_reg_wr(ex_reg_wr), .ex_illegal(ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        valid;
      logic [4:0]  conf;
      logic        sign;
      logic [31:0] in1;
      logic [31:0] in2;
      logic [4:0]  rd;
      logic        reg_wr;
      logic        illegal;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   function automatic exp_t mk(string nm, logic v, logic [4:0] c, logic s,
                               logic [31:0] a, logic [31:0] b, logic [4:0] d,
                               logic w, logic il);
      exp_t e;
      e.name = nm; e.valid = v; e.conf = c; e.sign = s; e.in1 = a; e.in2 = b;
      e.rd = d; e.reg_wr = w; e.illegal = il;
      return e;
   endfunction

   function automatic exp_t bubble(string nm);
      return mk(nm, 1'b0, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
   endfunction

   function automatic logic [31:0] r_ins(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                                         logic [4:0] sh, logic [5:0] fn);
      return {6'h00, rs, rt, rd, sh, fn};
   endfunction

   function automatic logic [31:0] i_ins(logic [5:0] op, logic [4:0] rs, logic [4:0] rt,
                                         logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   task automatic chk(string nm, string fld, logic [31:0] got, logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s.%s got=%h exp=%h", nm, fld, got, want);
      end
   endtask

   // Monitor: one expectation per clock edge, compared mid-cycle.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         exp_t e;
         e = exp_q.pop_front();
         chk(e.name, "valid",   32'(ex_valid),    32'(e.valid));
         chk(e.name, "conf",    32'(ex_alu_conf), 32'(e.conf));
         chk(e.name, "sign",    32'(ex_alu_sign), 32'(e.sign));
         chk(e.name, "in1",     ex_alu_in1,       e.in1);
         chk(e.name, "in2",     ex_alu_in2,       e.in2);
         chk(e.name, "rd",      32'(ex_rd),       32'(e.rd));
         chk(e.name, "reg_wr",  32'(ex_reg_wr),   32'(e.reg_wr));
         chk(e.name, "illegal", 32'(ex_illegal),  32'(e.illegal));
      end
   end

   task automatic step(input exp_t e);
      @(posedge clk);
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   task automatic ctl_idle();
      reset = 1'b0; stall = 1'b0; flush = 1'b0;
      exm_wr = 1'b0; exm_rd = 5'd0; exm_data = 32'd0;
      mwb_wr = 1'b0; mwb_rd = 5'd0; mwb_data = 32'd0;
   endtask

   task automatic drive(logic [31:0] ins, logic [31:0] rsd, logic [31:0] rtd);
      id_valid = 1'b1; id_instr = ins; id_rs_data = rsd; id_rt_data = rtd;
   endtask

   exp_t e_ill;
   exp_t e_xor;

   initial begin
      ctl_idle();
      reset = 1'b1;
      drive(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
`ifdef ALU_ISSUE_ILLEGAL_TRAP_EN
      e_ill = mk("illegal", 1'b1, 5'd0, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1);
`else
      e_ill = bubble("illegal");
`endif
      e_xor = mk("xor", 1'b1, 5'd4, 1'b0, 32'd5, 32'd7, 5'd10, 1'b1, 1'b0);

      step(bubble("reset0"));
      step(bubble("reset1"));
      reset = 1'b0;

      step(mk("add", 1'b1, 5'd0, 1'b1, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0));

      drive(r_ins(5'd0, 5'd2, 5'd4, 5'd3, 6'h03), 32'd0, 32'h8000_0000);
      step(mk("sra", 1'b1, 5'd8, 1'b0, 32'd3, 32'h8000_0000, 5'd4, 1'b1, 1'b0));

      drive(r_ins(5'd1, 5'd2, 5'd6, 5'd0, 6'h07), 32'h23, 32'h8000_0000);
      step(mk("srav", 1'b1, 5'd8, 1'b0, 32'd3, 32'h8000_0000, 5'd6, 1'b1, 1'b0));

      drive(i_ins(6'h08, 5'd1, 5'd5, 16'hFFFF), 32'h10, 32'd0);
      step(mk("addi", 1'b1, 5'd0, 1'b1, 32'h10, 32'hFFFF_FFFF, 5'd5, 1'b1, 1'b0));

      drive(i_ins(6'h0D, 5'd1, 5'd5, 16'hFFFF), 32'h10, 32'd0);
      step(mk("ori", 1'b1, 5'd3, 1'b0, 32'h10, 32'h0000_FFFF, 5'd5, 1'b1, 1'b0));

      drive(i_ins(6'h0F, 5'd0, 5'd7, 16'h1234), 32'd0, 32'd0);
      step(mk("lui", 1'b1, 5'd6, 1'b0, 32'd16, 32'h0000_1234, 5'd7, 1'b1, 1'b0));

      // EX/MEM must beat MEM/WB for the same source
      drive(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
      exm_wr = 1'b1; exm_rd = 5'd1; exm_data = 32'hA;
      mwb_wr = 1'b1; mwb_rd = 5'd1; mwb_data = 32'hB;
      step(mk("fwd_exm", 1'b1, 5'd0, 1'b1, 32'hA, 32'd7, 5'd3, 1'b1, 1'b0));

      exm_rd = 5'd4; mwb_rd = 5'd2;
      step(mk("fwd_mwb", 1'b1, 5'd0, 1'b1, 32'd5, 32'hB, 5'd3, 1'b1, 1'b0));

      ctl_idle();
      exm_wr = 1'b1; exm_rd = 5'd0; exm_data = 32'hA;
      drive(r_ins(5'd0, 5'd2, 5'd3, 5'd0, 6'h20), 32'h99, 32'd7);
      step(mk("fwd_r0", 1'b1, 5'd0, 1'b1, 32'h99, 32'd7, 5'd3, 1'b1, 1'b0));
      ctl_idle();

      drive(r_ins(5'd1, 5'd2, 5'd8, 5'd0, 6'h22), 32'd5, 32'd7);
      step(mk("sub", 1'b1, 5'd1, 1'b1, 32'd5, 32'd7, 5'd8, 1'b1, 1'b0));

      drive(r_ins(5'd1, 5'd2, 5'd9, 5'd0, 6'h2B), 32'd5, 32'd7);
      step(mk("sltu", 1'b1, 5'd9, 1'b0, 32'd5, 32'd7, 5'd9, 1'b1, 1'b0));

      drive(r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h20), 32'd5, 32'd7);
      step(mk("add_r0", 1'b1, 5'd0, 1'b1, 32'd5, 32'd7, 5'd0, 1'b0, 1'b0));

      drive(i_ins(6'h04, 5'd1, 5'd2, 16'h0010), 32'd5, 32'd7);
      step(mk("beq", 1'b1, 5'd1, 1'b0, 32'd5, 32'd7, 5'd2, 1'b0, 1'b0));

      // Stall holds across changing ID inputs, then stall+flush bubbles
      drive(r_ins(5'd1, 5'd2, 5'd10, 5'd0, 6'h26), 32'd5, 32'd7);
      step(e_xor);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(r_ins(5'd3, 5'd4, 5'd11, 5'd0, 6'h25), 32'(i + 100), 32'(i + 200));
         e_xor.name = $sformatf("stall%0d", i);
         step(e_xor);
      end
      flush = 1'b1;
      step(bubble("stall_flush"));
      ctl_idle();

      id_valid = 1'b0;
      drive(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h20), 32'd5, 32'd7);
      id_valid = 1'b0;
      step(bubble("id_invalid"));

      drive(r_ins(5'd1, 5'd2, 5'd10, 5'd0, 6'h26), 32'd5, 32'd7);
      e_xor.name = "xor2";
      step(e_xor);
      stall = 1'b1;
      step(mk("hold", 1'b1, 5'd4, 1'b0, 32'd5, 32'd7, 5'd10, 1'b1, 1'b0));
      reset = 1'b1;
      step(bubble("reset_in_stall"));
      ctl_idle();

      drive(i_ins(6'h3F, 5'd1, 5'd2, 16'h1234), 32'd5, 32'd7);
      step(e_ill);
      stall = 1'b1;
      e_ill.name = "illegal_hold";
      step(e_ill);
      stall = 1'b0; flush = 1'b1;
      step(bubble("illegal_flush"));
      flush = 1'b0;

      drive(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F), 32'd5, 32'd7);
      e_ill.name = "illegal_funct";
      step(e_ill);

      drive(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h24), 32'hF0F0, 32'h0FF0);
      step(mk("and_after_ill", 1'b1, 5'd2, 1'b0, 32'hF0F0, 32'h0FF0, 5'd3, 1'b1, 1'b0));

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain pending=%0d exp=0", exp_q.size());
      end
      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
